// File: rtl/alu_cc_stage_if.sv
// Handshake and data bundle for the registered ALU stage with condition codes.
// The master drives operations in and accepts results; the slave is the ALU stage.
interface alu_cc_stage_if #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       fn;
  logic             set_cc;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             cc_zf;
  logic             cc_sf;
  logic             cc_of;
  logic [CNT_W-1:0] op_count;

  modport master (
    output in_valid, a, b, fn, set_cc, out_ready,
    input  in_ready, out_valid, result, carry, cc_zf, cc_sf, cc_of, op_count
  );

  modport slave (
    input  in_valid, a, b, fn, set_cc, out_ready,
    output in_ready, out_valid, result, carry, cc_zf, cc_sf, cc_of, op_count
  );
endinterface

// File: rtl/alu_cc_stage.sv
// Registered ALU execute stage (add/sub/and/xor) with valid/ready output
// register, ZF/SF/OF condition-code register and accepted-operation counter.
module alu_cc_stage #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 32
) (
  input logic          clk,
  input logic          rst,
  alu_cc_stage_if.slave bus
);
  localparam int MSB = WIDTH - 1;

  logic [WIDTH:0]   sum_p0;
  logic [WIDTH-1:0] res_p0;
  logic [2:0]       flags_p0;
  logic             accept_p0;

  logic             vld_p1;
  logic [WIDTH-1:0] result_p1;
  logic             carry_p1;
  logic             zf_p1;
  logic             sf_p1;
  logic             of_p1;
  logic [CNT_W-1:0] cnt_p1;

  // Subtraction is a + ~b + 1, so the carry-out reads as "no borrow".
  function automatic logic [WIDTH:0] alu_core(input logic [WIDTH-1:0] op_a,
                                              input logic [WIDTH-1:0] op_b,
                                              input logic [1:0]       op_fn);
    logic [WIDTH:0] r;
    case (op_fn)
      2'b00:   r = {1'b0, op_a} + {1'b0, op_b};
      2'b01:   r = {1'b0, op_a} + {1'b0, ~op_b} + {{WIDTH{1'b0}}, 1'b1};
      2'b10:   r = {1'b0, op_a & op_b};
      default: r = {1'b0, op_a ^ op_b};
    endcase
    return r;
  endfunction

  // Returns {zf, sf, of}; overflow is judged from operand and result signs.
  function automatic logic [2:0] alu_flags(input logic signed [WIDTH-1:0] op_a,
                                           input logic signed [WIDTH-1:0] op_b,
                                           input logic signed [WIDTH-1:0] res,
                                           input logic [1:0]              op_fn);
    logic zf;
    logic sf;
    logic of;
    zf = (res == '0);
    sf = res[MSB];
    case (op_fn)
      2'b00:   of = (op_a[MSB] == op_b[MSB]) && (res[MSB] != op_a[MSB]);
      2'b01:   of = (op_a[MSB] != op_b[MSB]) && (res[MSB] != op_a[MSB]);
      default: of = 1'b0;
    endcase
    return {zf, sf, of};
  endfunction

  // Stage p0: combinational compute from the presented operands.
  assign sum_p0    = alu_core(bus.a, bus.b, bus.fn);
  assign res_p0    = sum_p0[WIDTH-1:0];
  assign flags_p0  = alu_flags(bus.a, bus.b, res_p0, bus.fn);
  assign accept_p0 = bus.in_valid && bus.in_ready;

  // Stage p1: result/CC/counter registers; reset wins over a same-edge accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      result_p1 <= '0;
      carry_p1  <= 1'b0;
      zf_p1     <= 1'b1;
      sf_p1     <= 1'b0;
      of_p1     <= 1'b0;
      cnt_p1    <= '0;
    end else if (accept_p0) begin
      vld_p1    <= 1'b1;
      result_p1 <= res_p0;
      carry_p1  <= sum_p0[WIDTH];
      cnt_p1    <= cnt_p1 + {{(CNT_W-1){1'b0}}, 1'b1};
      if (bus.set_cc) begin
        zf_p1 <= flags_p0[2];
        sf_p1 <= flags_p0[1];
        of_p1 <= flags_p0[0];
      end
    end else if (bus.out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign bus.in_ready  = !vld_p1 || bus.out_ready;
  assign bus.out_valid = vld_p1;
  assign bus.result    = result_p1;
  assign bus.carry     = carry_p1;
  assign bus.cc_zf     = zf_p1;
  assign bus.cc_sf     = sf_p1;
  assign bus.cc_of     = of_p1;
  assign bus.op_count  = cnt_p1;
endmodule

// File: tb/tb_alu_cc_stage.sv
// Scoreboard bench for alu_cc_stage: driver pushes model results on accept,
// a negedge monitor pops and compares when the DUT hands a result downstream.
module tb_alu_cc_stage;
  localparam int W   = 64;
  localparam int CNT = 3;

  typedef struct {
    logic [W-1:0] r;
    logic         c;
    logic         zf;
    logic         sf;
    logic         of;
  } item_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  alu_cc_stage_if #(.WIDTH(W), .CNT_W(CNT)) bus ();
  alu_cc_stage #(.WIDTH(W), .CNT_W(CNT)) dut (.clk(clk), .rst(rst), .bus(bus));

  item_t q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  bit    mon_en  = 1'b0;
  logic  m_vld   = 1'b0;
  int    m_acc   = 0;
  logic  m_zf    = 1'b1;
  logic  m_sf    = 1'b0;
  logic  m_of    = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, req);
    end
  endtask

  // Reference: operands as wide integers; carry = unsigned result exceeds W bits
  // (or no borrow), overflow = true signed result falls outside the W-bit range.
  task automatic ref_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] fn,
                        output logic [W-1:0] r, output logic c, output logic zf,
                        output logic sf, output logic of);
    logic [2*W-1:0]        u;
    logic signed [2*W-1:0] sa, sb, s, smax, smin;
    sa   = $signed({{W{a[W-1]}}, a});
    sb   = $signed({{W{b[W-1]}}, b});
    smax = $signed({{(W+1){1'b0}}, {(W-1){1'b1}}});
    smin = -smax - 1;
    c = 1'b0;
    of = 1'b0;
    case (fn)
      2'b00: begin
        u = {{W{1'b0}}, a} + {{W{1'b0}}, b};
        r = u[W-1:0];
        c = (u >> W) != 0;
        s = sa + sb;
        of = (s > smax) || (s < smin);
      end
      2'b01: begin
        r = a - b;
        c = (a >= b);
        s = sa - sb;
        of = (s > smax) || (s < smin);
      end
      2'b10:   r = a & b;
      default: r = a ^ b;
    endcase
    zf = (r == 0);
    sf = ($signed(r) < 0);
  endtask

  task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [1:0] fn, input logic sc, input logic ordy, input logic r);
    logic  acc;
    item_t it;
    logic  zf, sf, of;
    bus.in_valid  = v;
    bus.a         = a;
    bus.b         = b;
    bus.fn        = fn;
    bus.set_cc    = sc;
    bus.out_ready = ordy;
    rst           = r;
    acc = !r && v && (!m_vld || ordy);
    if (acc) begin
      ref_op(a, b, fn, it.r, it.c, zf, sf, of);
      if (sc) begin
        m_zf = zf;
        m_sf = sf;
        m_of = of;
      end
      it.zf = m_zf;
      it.sf = m_sf;
      it.of = m_of;
      q.push_back(it);
    end
    @(posedge clk);
    #1;
    if (r) begin
      m_vld = 1'b0;
      m_acc = 0;
      m_zf  = 1'b1;
      m_sf  = 1'b0;
      m_of  = 1'b0;
      q.delete();
    end else if (acc) begin
      m_vld = 1'b1;
      m_acc++;
    end else if (ordy) begin
      m_vld = 1'b0;
    end
  endtask

  function automatic logic [W-1:0] rnd_opnd();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return {1'b1, {(W-1){1'b0}}};
      3:       return {1'b0, {(W-1){1'b1}}};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      chk("out_valid", 64'(bus.out_valid), 64'(m_vld));
      chk("in_ready", 64'(bus.in_ready), 64'(!m_vld || bus.out_ready));
      chk("op_count", 64'(bus.op_count), 64'(m_acc % (1 << CNT)));
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          chk("sb_nonempty", 64'(q.size()), 64'd1);
        end else begin
          chk("result", bus.result, q[0].r);
          chk("carry", 64'(bus.carry), 64'(q[0].c));
          chk("cc_zf", 64'(bus.cc_zf), 64'(q[0].zf));
          chk("cc_sf", 64'(bus.cc_sf), 64'(q[0].sf));
          chk("cc_of", 64'(bus.cc_of), 64'(q[0].of));
          if (bus.out_ready) void'(q.pop_front());
        end
      end
    end
  end

  localparam logic [W-1:0] H4 = 64'h4000_0000_0000_0000;
  localparam logic [W-1:0] H8 = 64'h8000_0000_0000_0000;
  localparam logic [W-1:0] H6 = 64'h6000_0000_0000_0000;
  localparam logic [W-1:0] HE = 64'hE000_0000_0000_0000;
  localparam logic [W-1:0] H7 = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [W-1:0] HF = 64'hFFFF_FFFF_FFFF_FFFF;

  initial begin
    int sv;
    // Reset with an operation presented
    step(1'b1, 64'd1, 64'd2, 2'b00, 1'b1, 1'b0, 1'b1);
    step(1'b1, 64'd3, 64'd4, 2'b00, 1'b1, 1'b0, 1'b1);
    bus.in_valid = 1'b0;
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_zf", 64'(bus.cc_zf), 64'd1);
    chk("rst_sf", 64'(bus.cc_sf), 64'd0);
    chk("rst_of", 64'(bus.cc_of), 64'd0);
    chk("rst_cnt", 64'(bus.op_count), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_result", bus.result, 64'd0);
    mon_en = 1'b1;

    // Directed arithmetic and flags
    step(1'b1, H4, H4, 2'b00, 1'b1, 1'b1, 1'b0);
    chk("addov_res", bus.result, H8);
    chk("addov_c", 64'(bus.carry), 64'd0);
    chk("addov_flags", 64'({bus.cc_zf, bus.cc_sf, bus.cc_of}), 64'b011);
    step(1'b1, H8, H8, 2'b00, 1'b1, 1'b1, 1'b0);
    chk("addwrap_res", bus.result, 64'd0);
    chk("addwrap_c", 64'(bus.carry), 64'd1);
    chk("addwrap_flags", 64'({bus.cc_zf, bus.cc_sf, bus.cc_of}), 64'b101);
    step(1'b1, 64'hA, 64'h5, 2'b01, 1'b1, 1'b1, 1'b0);
    chk("sub_res", bus.result, 64'd5);
    chk("sub_c", 64'(bus.carry), 64'd1);
    chk("sub_of", 64'(bus.cc_of), 64'd0);
    step(1'b1, H6, H8, 2'b01, 1'b1, 1'b1, 1'b0);
    chk("subov1_sf_of", 64'({bus.cc_sf, bus.cc_of}), 64'b11);
    step(1'b1, HE, H7, 2'b01, 1'b1, 1'b1, 1'b0);
    chk("subov2_sf_of", 64'({bus.cc_sf, bus.cc_of}), 64'b01);
    step(1'b1, HF, HF, 2'b00, 1'b1, 1'b1, 1'b0);
    chk("ones_add_res", bus.result, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("ones_add_c_of", 64'({bus.carry, bus.cc_of}), 64'b10);
    step(1'b1, HF, HF, 2'b10, 1'b1, 1'b1, 1'b0);
    chk("ones_and_res", bus.result, HF);
    step(1'b1, HF, HF, 2'b11, 1'b1, 1'b1, 1'b0);
    chk("ones_xor", 64'({bus.result[7:0], bus.carry, bus.cc_zf}), 64'h001);
    step(1'b1, 64'd1, 64'd1, 2'b00, 1'b0, 1'b1, 1'b0);
    chk("nocc_res", bus.result, 64'd2);
    chk("nocc_flags", 64'({bus.cc_zf, bus.cc_sf, bus.cc_of}), 64'b100);

    // Backpressure: stalled input with changing operands is not sampled
    step(1'b1, 64'd3, 64'd4, 2'b00, 1'b1, 1'b1, 1'b0);
    sv = m_acc;
    for (int i = 0; i < 3; i++)
      step(1'b1, rnd_opnd(), rnd_opnd(), 2'($urandom_range(0, 3)), 1'b1, 1'b0, 1'b0);
    chk("stall_res", bus.result, 64'd7);
    chk("stall_cnt", 64'(bus.op_count), 64'(sv % (1 << CNT)));
    chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
    for (int i = 0; i < 4; i++)
      step(1'b1, rnd_opnd(), rnd_opnd(), 2'($urandom_range(0, 3)), 1'b1, 1'b1, 1'b0);
    chk("b2b_cnt", 64'(bus.op_count), 64'((sv + 4) % (1 << CNT)));

    // Randomized traffic
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 3) != 0), rnd_opnd(), rnd_opnd(), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) < 7), 1'b0);

    // Counter wrap, then reset while a result is held and a new op presented
    step(1'b0, '0, '0, 2'b00, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 9; i++)
      step(1'b1, rnd_opnd(), rnd_opnd(), 2'($urandom_range(0, 3)), 1'b1, 1'b1, 1'b0);
    chk("cnt_wrap", 64'(bus.op_count), 64'd1);
    step(1'b1, 64'd9, 64'd9, 2'b00, 1'b1, 1'b0, 1'b1);
    chk("midrst_vld", 64'(bus.out_valid), 64'd0);
    chk("midrst_cnt", 64'(bus.op_count), 64'd0);
    chk("midrst_zf", 64'(bus.cc_zf), 64'd1);

    // Drain and confirm the scoreboard emptied
    step(1'b1, 64'd5, 64'd6, 2'b11, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      step(1'b0, '0, '0, 2'b00, 1'b0, 1'b1, 1'b0);
    chk("sb_drained", 64'(q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_cc_stage.md
# alu_cc_stage

Registered, parametrised-width ALU stage with a valid/ready handshake and a Y86-style condition-code register (ZF/SF/OF). It supersedes the fixed 64-bit combinational ALU for pipelined datapaths.

- Execute stage: accepts one operation per cycle and holds the result in an output register until downstream accepts it.
- CC register: updated only on operations that request it. It feeds branch and conditional-move logic.

## Interface
Parameters:
- WIDTH, 64, operand/result width in bits (legal: >= 2)
- CNT_W, 32, width of the accepted-operation counter

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  operation presented
- in_ready  out  1  stage can accept; in_ready = !out_valid || out_ready
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- fn  in  2  00 add A+B, 01 sub A-B, 10 and A&B, 11 xor A^B
- set_cc  in  1  update CC register with this operation's flags
- out_valid  out  1  result register holds an unconsumed result
- out_ready  in  1  downstream accepts result
- result  out  WIDTH  registered result
- carry  out  1  registered carry-out of MSB
- cc_zf, cc_sf, cc_of  out  1 each  condition-code register
- op_count  out  CNT_W  number of accepted operations

## Operation
- Accept: in_valid && in_ready at a rising edge.
- On accept:
  - result, carry and out_valid<=1 load from the combinational computation of a, b, fn.
  - fn and set_cc are sampled on the same edge.
- Arithmetic is computed at WIDTH+1 bits:
  - add: {carry,result} = a + b.
  - sub: {carry,result} = a + ~b + 1. carry=1 means no borrow.
  - and/xor: carry = 0.
- Flags, computed from the new result:
  - ZF = (result == 0).
  - SF = result[WIDTH-1].
  - OF for add = (a[MSB] == b[MSB]) && (result[MSB] != a[MSB]).
  - OF for sub = (a[MSB] != b[MSB]) && (result[MSB] != a[MSB]).
  - OF for and/xor = 0.
- CC update: when set_cc=1, cc_zf/cc_sf/cc_of load the new flags on the accept edge. When set_cc=0, they hold.
- Output handshake:
  - On out_valid && out_ready with no simultaneous accept, out_valid clears.
  - On a simultaneous accept, the new result replaces the old one and out_valid stays 1. Throughput is one operation per cycle.
- Backpressure: while out_valid && !out_ready, in_ready=0. result, carry and flags stay stable and no CC update occurs.
- op_count increments by 1 per accept and wraps modulo 2^CNT_W.
- Invariants:
  - Inputs are ignored when no accept occurs, including set_cc.
  - The block carries no state other than the registers listed above.

## Timing
- Latency: 1 cycle. An operation accepted at edge N is visible on result/out_valid after edge N. It is consumed at the first edge with out_ready=1, N+1 at the earliest.
- CC latency: 1 cycle, updated at the same edge the result register loads.
- in_ready is combinational from out_valid and out_ready. There is no combinational path from a/b/fn to any output.
- Reset (rst=1 at an edge):
  - out_valid=0, result=0, carry=0, cc_zf=1, cc_sf=0, cc_of=0, op_count=0.
  - Reset overrides a simultaneous accept. Any in-flight result is discarded.
  - in_ready is 1 after reset.
- Boundary cases:
  - Full: out_valid=1, out_ready=0 blocks input.
  - Drain and refill in the same cycle is allowed.
  - op_count wraps from all-ones to 0.
  - A held in_valid with changing operands while in_ready=0 is not sampled.

## Test plan
- Reset: rst=1 for 2 cycles with in_valid=1 -> out_valid=0, cc_zf=1, cc_sf=0, cc_of=0, op_count=0, in_ready=1.
- Add overflow (WIDTH=64): a=b=0x4000_0000_0000_0000, fn=00, set_cc=1 -> next cycle result=0x8000_0000_0000_0000, carry=0, cc_of=1, cc_sf=1, cc_zf=0. With a=b=0x8000_0000_0000_0000 -> result=0, carry=1, cc_zf=1, cc_of=1.
- Sub: a=0xA, b=0x5, fn=01 -> result=5, carry=1, OF=0.
  - a=0x6000…0, b=0x8000…0 -> OF=1, SF=1.
  - a=0xE000…0, b=0x7FFF…F -> OF=1, SF=0.
- Logic and all-ones: a=b=all-ones with fn=00 -> result=0xFFFF…FE, carry=1, OF=0. Same operands with fn=10 -> all-ones. With fn=11 -> 0, carry=0, ZF=1.
- CC hold and backpressure:
  - Accept an op with set_cc=0 -> CC unchanged.
  - Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, result stable, op_count unchanged.
  - Then assert out_ready=1 -> back-to-back accepts every cycle.
- Reset mid-stream and wrap: with CNT_W=3, accept 9 ops -> op_count=1. Assert rst while out_valid=1 and a new op is presented -> out_valid=0, op_count=0.
